// File: rtl/mac_accum_engine_if.sv
// rtl/mac_accum_engine_if.sv - beat input and result output streams of the MAC engine
interface mac_accum_engine_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] act;
  logic [DATA_W-1:0] wt;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;

  modport master (
    output in_valid, act, wt, out_ready,
    input  in_ready, out_valid, out_data, out_idx
  );

  modport slave (
    input  in_valid, act, wt, out_ready,
    output in_ready, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/mac_accum_engine.sv
// rtl/mac_accum_engine.sv - fixed-point multiply-accumulate bank with ordered result drain
// Define MAC_ACCUM_SAT_EN to saturate product scaling and accumulation instead of wrapping.
module mac_accum_engine #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int N_IN   = 16,
  parameter int N_OUT  = 10,
  parameter int IDX_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  mac_accum_engine_if.slave  bus,
  output logic               busy,
  output logic               done
);
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IW-1:0]    I_LAST = IW'(N_IN - 1);
  localparam logic [IDX_W-1:0] J_LAST = IDX_W'(N_OUT - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                   state;
  logic [IW-1:0]            i;
  logic [IDX_W-1:0]         j;
  logic [IDX_W-1:0]         k;
  logic signed [DATA_W-1:0] acc [N_OUT];

  logic signed [2*DATA_W-1:0] prod;
  logic signed [2*DATA_W-1:0] prod_sh;
  logic signed [DATA_W-1:0]   scaled;
  logic signed [DATA_W-1:0]   sum;
  logic                       beat;

  assign beat = bus.in_valid && bus.in_ready;

`ifdef MAC_ACCUM_SAT_EN
  localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  logic signed [DATA_W:0] wide;

  always_comb begin
    prod    = $signed(bus.act) * $signed(bus.wt);
    prod_sh = prod >>> FRAC_W;
    // Discarded upper bits must all equal the kept sign bit, otherwise clamp.
    if (prod_sh[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){prod_sh[DATA_W-1]}})
      scaled = prod_sh[2*DATA_W-1] ? S_MIN : S_MAX;
    else
      scaled = prod_sh[DATA_W-1:0];
    wide = {acc[j][DATA_W-1], acc[j]} + {scaled[DATA_W-1], scaled};
    if (wide[DATA_W] != wide[DATA_W-1])
      sum = wide[DATA_W] ? S_MIN : S_MAX;
    else
      sum = wide[DATA_W-1:0];
  end
`else
  always_comb begin
    prod    = $signed(bus.act) * $signed(bus.wt);
    prod_sh = prod >>> FRAC_W;
    scaled  = DATA_W'(prod_sh);
    sum     = acc[j] + scaled;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      i             <= '0;
      j             <= '0;
      k             <= '0;
      for (int n = 0; n < N_OUT; n++) acc[n] <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_idx   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= ACCUM;
            i            <= '0;
            j            <= '0;
            for (int n = 0; n < N_OUT; n++) acc[n] <= '0;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc[j] <= sum;
            if (j == J_LAST) begin
              j <= '0;
              if (i == I_LAST) begin
                state         <= DRAIN;
                i             <= '0;
                k             <= '0;
                bus.in_ready  <= 1'b0;
                bus.out_valid <= 1'b1;
                bus.out_idx   <= '0;
                // With a single neuron the first result is the sum being written now.
                bus.out_data  <= (j == '0) ? sum : acc[0];
              end else begin
                i <= i + 1'b1;
              end
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (k == J_LAST) begin
              state         <= IDLE;
              k             <= '0;
              bus.out_valid <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
            end else begin
              k            <= k + 1'b1;
              bus.out_idx  <= k + 1'b1;
              bus.out_data <= acc[k + 1'b1];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
